// File: rtl/input_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_capture_if
//  Description : Switch/enter inputs and capture outputs of input_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_capture_if;
    logic        in;
    logic [3:0]  sw;
    logic        enter;
    logic        input_valid;
    logic [31:0] data_out;
    logic        waiting;
    logic        enter_stable;

    modport master (
        output in, sw, enter,
        input  input_valid, data_out, waiting, enter_stable
    );

    modport slave (
        input  in, sw, enter,
        output input_valid, data_out, waiting, enter_stable
    );
endinterface
`default_nettype wire

// File: rtl/input_capture.sv
`default_nettype none
// ============================================================================
//  Module      : input_capture
//  Description : Synchronises and debounces the switches/enter key and hands
//                one captured switch word to the datapath per enter press.
//                Define INPUT_CAPTURE_SIGNED_EN to sign-extend the 4-bit value.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic            clk,
    input  logic            reset,
    input_capture_if.slave  bus
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_ARMED   = 2'd1;
    localparam logic [1:0]       c_RELEASE = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [3:0]       r_sw_meta;
    logic [3:0]       r_sw_s;
    logic             r_en_meta;
    logic             r_en_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_enter_stable;
    logic             r_enter_stable_d;
    logic [1:0]       r_state;
    logic             r_input_valid;
    logic [31:0]      r_data_out;
    logic             w_rise;
    logic [31:0]      w_capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= 4'd0;
            r_sw_s    <= 4'd0;
            r_en_meta <= 1'b0;
            r_en_s    <= 1'b0;
        end else begin
            r_sw_meta <= bus.sw;
            r_sw_s    <= r_sw_meta;
            r_en_meta <= bus.enter;
            r_en_s    <= r_en_meta;
        end
    end

    // The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt            <= '0;
            r_enter_stable   <= 1'b0;
            r_enter_stable_d <= 1'b0;
        end else begin
            r_enter_stable_d <= r_enter_stable;
            if (r_en_s == r_enter_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_cnt          <= '0;
                r_enter_stable <= ~r_enter_stable;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign w_rise = r_enter_stable & ~r_enter_stable_d;

`ifdef INPUT_CAPTURE_SIGNED_EN
    assign w_capture = {{28{r_sw_s[3]}}, r_sw_s};
`else
    assign w_capture = {28'd0, r_sw_s};
`endif

    // A dropped request in ARMED wins over a simultaneous rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_input_valid <= 1'b0;
            r_data_out    <= 32'd0;
        end else begin
            r_input_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.in) begin
                        r_state <= c_ARMED;
                    end
                end
                c_ARMED: begin
                    if (!bus.in) begin
                        r_state <= c_IDLE;
                    end else if (w_rise) begin
                        r_input_valid <= 1'b1;
                        r_data_out    <= w_capture;
                        r_state       <= c_RELEASE;
                    end
                end
                c_RELEASE: begin
                    if (!r_enter_stable && !bus.in) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.input_valid  = r_input_valid;
    assign bus.data_out     = r_data_out;
    assign bus.waiting      = (r_state == c_ARMED);
    assign bus.enter_stable = r_enter_stable;

endmodule
`default_nettype wire

// File: doc/input_capture.md
# input_capture

Synchronises, debounces and captures the four data switches and the enter switch for the datapath's read-input instruction. It sits directly upstream of the datapath. While the datapath holds `in` high (stalled on an input instruction), the block waits for a clean enter press. It then delivers the switch value as a 32-bit word with a one-cycle `input_valid` pulse.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive clk cycles a synchronised enter level must differ from the stable level before the stable level changes. Must be ≥ 2.
- `CNT_W`, default 5: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: divided system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `in` in 1: input request from the datapath. Level, held high until `input_valid` is seen.
- `sw` in 4: raw, asynchronous data switches.
- `enter` in 1: raw, asynchronous enter switch; high = pressed.
- `input_valid` out 1: one-cycle pulse; `data_out` is valid this cycle.
- `data_out` out 32: captured switch value; holds until the next capture.
- `waiting` out 1: high in ARMED (request pending, awaiting press). Intended for a display "enter value" indicator.
- `enter_stable` out 1: debounced enter level, for debug.

## Operation
- Synchroniser: 2-flop chain on `sw[3:0]` and `enter`. Produces `sw_s` and `en_s`.
- Debouncer:
  - `cnt` clears on any edge where `en_s == enter_stable`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, `enter_stable` toggles and `cnt` clears; else `cnt` increments.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `enter_stable`.
- `rise` = `enter_stable & ~enter_stable_d`. `enter_stable_d` is a one-cycle delayed copy.
- FSM states and transitions:
  - IDLE: if `in == 1`, go to ARMED.
  - ARMED:
    - If `in == 0`, go to IDLE with no pulse (datapath reset or abort).
    - Else if `rise`, register `input_valid = 1`, capture `data_out` from `sw_s`, and go to RELEASE.
  - RELEASE: stay until `enter_stable == 0` AND `in == 0`, then go to IDLE. No further pulses occur here, even if `in` stays high.
- An enter already held when ARMED is entered does not fire. A fresh debounced rising edge observed in ARMED is required.
- Presses while in IDLE are ignored. No value is queued.
- `input_valid` is high for exactly one cycle per capture and is never asserted outside the ARMED→RELEASE transition.
- Reset values: state IDLE; `input_valid` 0; `data_out` 0; `waiting` 0; `enter_stable` 0; `cnt` 0; synchroniser flops 0.
- Reset asserted mid-debounce or mid-handshake aborts immediately. No pulse is emitted on the reset edge or the edge after.

## Timing
- Let E0 be the first edge sampling `enter = 1`. Then:
  - `en_s = 1` after E1.
  - `enter_stable = 1` after E(1+DEBOUNCE_CYCLES).
  - `input_valid = 1` after E(2+DEBOUNCE_CYCLES), for one cycle, provided the block is in ARMED.
- `data_out` takes `sw_s` at the same edge that sets `input_valid`. Switch changes within 2 cycles before that edge are not guaranteed to be captured.
- Release latency is symmetric: `enter_stable` falls DEBOUNCE_CYCLES+1 edges after the first low sample.
- `waiting` rises one edge after `in` rises, and falls on the edge that sets `input_valid` or on the edge where `in == 0` is seen.
- Simultaneous `in` falling and `rise` in ARMED: `in == 0` has priority, giving no pulse and a return to IDLE.

## Configuration
- `INPUT_CAPTURE_SIGNED_EN`:
  - Defined: `data_out = {{28{sw_s[3]}}, sw_s}`, a signed range of −8..7.
  - Undefined: `data_out = {28'b0, sw_s}`, an unsigned range of 0..15.
  - All timing is identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Basic capture: `reset` for 2 cycles, then `in = 1`, `sw = 4'b0101`, `enter = 1` sampled at E0 → `input_valid` pulses exactly once, high after E6, with `data_out = 32'h00000005`. `waiting` goes 1 → 0.
- Bounce rejection: in ARMED, drive `enter` as 1 for 3 cycles, 0 for 1, 1 for 3, then 0 → `enter_stable` stays 0 and there is no `input_valid`. Then hold `enter` high for 8 cycles → exactly one pulse.
- Held enter: hold `enter` high, raise `in` → no pulse. Release for ≥ 6 cycles, press again → one pulse. Keeping `in` high while pressing again in RELEASE gives no second pulse.
- Abort: in ARMED, drop `in` on the same edge `rise` occurs → no pulse, state IDLE, `waiting = 0`, `data_out` unchanged.
- Signed build: with the macro defined, `sw = 4'b1010` → `data_out = 32'hFFFFFFFA`. Without the macro, the same stimulus gives `32'h0000000A`.
- Reset mid-operation: assert `reset` with `cnt = 2` in ARMED → next cycle all outputs are 0, and no pulse occurs for 2 cycles after deassertion even with `enter` held.
